lab1_seq_ctrl: RTL and testbench

Sequencing controller for the Lab1 3-bit operand / 2-bit select / 8-bit result ALU datapath. It accepts one operand pair per command and holds the operands on the ALU inputs. It then steps the ALU select through 0 to `LAST_SEL`, waits a programmable settle time per step, and captures each 8-bit result. Each result is delivered to a consumer over a valid/ready handshake, and completion is signalled with a one-cycle `done` pulse.

---
 rtl/lab1_seq_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_lab1_seq_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lab1_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : lab1_seq_ctrl
//  Purpose  : Sequencing controller for the Lab1 ALU datapath. It latches an
//             operand pair and sweeps the ALU select from 0 to LAST_SEL. It
//             waits SETTLE_CYCLES per step and captures each result. Results
//             are handed over with valid/ready, and a one-cycle done pulse
//             marks the end of the sweep.
//  Options  : LAB1_SEQ_CHECKSUM_EN adds the res_sum running-sum output.
//  Revision : 1.0 - initial release
// ============================================================================
module lab1_seq_ctrl #(
  parameter int SETTLE_CYCLES = 1,
  parameter int LAST_SEL      = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] x_in,
  input  logic [2:0] y_in,
  input  logic [7:0] alu_out,
  output logic [2:0] alu_x,
  output logic [2:0] alu_y,
  output logic [1:0] alu_sel,
  output logic       busy,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [1:0] res_sel,
  output logic [7:0] res_data,
  output logic       done
`ifdef LAB1_SEQ_CHECKSUM_EN
  ,
  output logic [9:0] res_sum
`endif
);

  // Counter value on which the settled ALU result is captured.
  localparam logic [3:0] c_settle_last = 4'(SETTLE_CYCLES - 1);
  localparam logic [1:0] c_last_sel    = 2'(LAST_SEL);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_EMIT   = 2'd2
  } state_t;

  state_t      state_q,     state_d;
  logic [3:0]  cnt_q,       cnt_d;
  logic [2:0]  alu_x_q,     alu_x_d;
  logic [2:0]  alu_y_q,     alu_y_d;
  logic [1:0]  alu_sel_q,   alu_sel_d;
  logic        busy_q,      busy_d;
  logic        res_valid_q, res_valid_d;
  logic [1:0]  res_sel_q,   res_sel_d;
  logic [7:0]  res_data_q,  res_data_d;
  logic        done_q,      done_d;
`ifdef LAB1_SEQ_CHECKSUM_EN
  logic [9:0]  sum_q,       sum_d;
`endif

  // The consumer takes the pending result on this edge.
  logic w_handshake;
  assign w_handshake = res_valid_q & res_ready;

  // Next-state and next-output computation for the sweep sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_x_d     = alu_x_q;
    alu_y_d     = alu_y_q;
    alu_sel_d   = alu_sel_q;
    busy_d      = busy_q;
    res_valid_d = res_valid_q;
    res_sel_d   = res_sel_q;
    res_data_d  = res_data_q;
    done_d      = 1'b0;
`ifdef LAB1_SEQ_CHECKSUM_EN
    sum_d       = sum_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          alu_x_d   = x_in;
          alu_y_d   = y_in;
          alu_sel_d = 2'd0;
          cnt_d     = 4'd0;
          busy_d    = 1'b1;
          state_d   = S_SETTLE;
`ifdef LAB1_SEQ_CHECKSUM_EN
          sum_d     = 10'd0;
`else
          // Without the checksum there is nothing else to clear at start.
`endif
        end
      end

      S_SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == c_settle_last) begin
          res_data_d  = alu_out;
          res_sel_d   = alu_sel_q;
          res_valid_d = 1'b1;
          state_d     = S_EMIT;
        end
      end

      S_EMIT: begin
        // Result registers are untouched until the consumer takes them.
        if (w_handshake) begin
          res_valid_d = 1'b0;
`ifdef LAB1_SEQ_CHECKSUM_EN
          sum_d       = sum_q + {2'b00, res_data_q};
`endif
          if (alu_sel_q == c_last_sel) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            alu_sel_d = alu_sel_q + 2'd1;
            cnt_d     = 4'd0;
            state_d   = S_SETTLE;
          end
        end
      end

      default: begin
        busy_d      = 1'b0;
        res_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State and output registers; synchronous active-low reset aborts any sweep.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      alu_x_q     <= 3'd0;
      alu_y_q     <= 3'd0;
      alu_sel_q   <= 2'd0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_sel_q   <= 2'd0;
      res_data_q  <= 8'd0;
      done_q      <= 1'b0;
`ifdef LAB1_SEQ_CHECKSUM_EN
      sum_q       <= 10'd0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_x_q     <= alu_x_d;
      alu_y_q     <= alu_y_d;
      alu_sel_q   <= alu_sel_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      res_sel_q   <= res_sel_d;
      res_data_q  <= res_data_d;
      done_q      <= done_d;
`ifdef LAB1_SEQ_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign alu_x     = alu_x_q;
  assign alu_y     = alu_y_q;
  assign alu_sel   = alu_sel_q;
  assign busy      = busy_q;
  assign res_valid = res_valid_q;
  assign res_sel   = res_sel_q;
  assign res_data  = res_data_q;
  assign done      = done_q;
`ifdef LAB1_SEQ_CHECKSUM_EN
  assign res_sum   = sum_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lab1_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lab1_seq_ctrl
//  Purpose  : Self-checking bench for lab1_seq_ctrl using an ALU stub
//             alu_out = {alu_sel, alu_x, alu_y}. It instantiates one default
//             instance and one instance with SETTLE_CYCLES=3, LAST_SEL=2.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lab1_seq_ctrl;
  localparam int S1 = 1;
  localparam int L1 = 3;
  localparam int S2 = 3;
  localparam int L2 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic       rst_n, start, res_ready;
  logic [2:0] x_in, y_in, alu_x, alu_y;
  logic [7:0] alu_out, res_data;
  logic [1:0] alu_sel, res_sel;
  logic       busy, res_valid, done;
`ifdef LAB1_SEQ_CHECKSUM_EN
  logic [9:0] res_sum;
`endif
  assign alu_out = {alu_sel, alu_x, alu_y};

  lab1_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x_in(x_in), .y_in(y_in),
    .alu_out(alu_out), .alu_x(alu_x), .alu_y(alu_y), .alu_sel(alu_sel),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .res_sel(res_sel), .res_data(res_data), .done(done)
`ifdef LAB1_SEQ_CHECKSUM_EN
    , .res_sum(res_sum)
`endif
  );

  // SETTLE_CYCLES=3, LAST_SEL=2 instance
  logic       b_rst_n, b_start, b_ready;
  logic [2:0] b_x, b_y, b_alu_x, b_alu_y;
  logic [7:0] b_alu_out, b_data;
  logic [1:0] b_alu_sel, b_sel;
  logic       b_busy, b_valid, b_done;
`ifdef LAB1_SEQ_CHECKSUM_EN
  logic [9:0] b_sum;
`endif
  assign b_alu_out = {b_alu_sel, b_alu_x, b_alu_y};

  lab1_seq_ctrl #(.SETTLE_CYCLES(S2), .LAST_SEL(L2)) dut2 (
    .clk(clk), .rst_n(b_rst_n), .start(b_start), .x_in(b_x), .y_in(b_y),
    .alu_out(b_alu_out), .alu_x(b_alu_x), .alu_y(b_alu_y), .alu_sel(b_alu_sel),
    .busy(b_busy), .res_valid(b_valid), .res_ready(b_ready),
    .res_sel(b_sel), .res_data(b_data), .done(b_done)
`ifdef LAB1_SEQ_CHECKSUM_EN
    , .res_sum(b_sum)
`endif
  );

  int checks = 0;
  int errors = 0;
  bit found;

  typedef struct {
    bit         rdy;
    bit         busy;
    bit         valid;
    bit         done;
    logic [1:0] asel;
    logic [1:0] rsel;
    logic [7:0] data;
  } vec_t;
  vec_t vec [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Reference model of one sweep on the default instance: a result becomes
  // valid S1 edges after start or after the previous handshake, result k is
  // k*64 + x*8 + y, and done follows the handshake of result L1.
  task automatic run_sweep(input logic [2:0] x, input logic [2:0] y,
                           input bit rand_rdy, input bit mid_start);
    int  since, k;
    bit  fin, exp_v, hs;
    int  sum;
    since = 0; k = 0; fin = 0; sum = 0;
    start = 1'b1; x_in = x; y_in = y;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 300 && !fin; c++) begin
      res_ready = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (mid_start && c == 1) begin
        start = 1'b1; x_in = ~x; y_in = ~y;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      exp_v = (since >= S1);
      check("sw_valid", res_valid, exp_v);
      check("sw_busy", busy, 1);
      check("sw_done", done, 0);
      check("sw_alu_x", alu_x, x);
      check("sw_alu_y", alu_y, y);
      check("sw_alu_sel", alu_sel, k);
      if (exp_v) begin
        check("sw_data", res_data, k * 64 + x * 8 + y);
        check("sw_rsel", res_sel, k);
      end
      hs = exp_v && res_ready;
      @(posedge clk); #1;
      if (hs) begin
        sum += k * 64 + x * 8 + y;
        if (k == L1) fin = 1;
        else begin k++; since = 0; end
      end else begin
        since++;
      end
    end
    start = 1'b0;
    check("sw_finished", fin, 1);
    @(negedge clk);
    check("sw_done_pulse", done, 1);
    check("sw_idle_busy", busy, 0);
    check("sw_idle_valid", res_valid, 0);
`ifdef LAB1_SEQ_CHECKSUM_EN
    check("sw_sum", res_sum, sum);
`endif
  endtask

  initial begin
    // Expected outputs after edge i of the X=5, Y=3 sweep with res_ready=1.
    vec[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 8'h00};
    vec[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 8'h2B};
    vec[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 2'd0, 8'h00};
    vec[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 2'd1, 8'h6B};
    vec[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 2'd0, 8'h00};
    vec[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 2'd2, 8'hAB};
    vec[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 2'd0, 8'h00};
    vec[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd3, 2'd3, 8'hEB};
    vec[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 2'd0, 8'h00};
    vec[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 2'd0, 8'h00};

    rst_n = 1'b0; start = 1'b0; x_in = 3'd0; y_in = 3'd0; res_ready = 1'b0;
    b_rst_n = 1'b0; b_start = 1'b0; b_x = 3'd0; b_y = 3'd0; b_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", res_valid, 0);
    check("rst_done", done, 0);
    check("rst_alu", {alu_x, alu_y, alu_sel}, 0);
    check("rst_res", {res_sel, res_data}, 0);
`ifdef LAB1_SEQ_CHECKSUM_EN
    check("rst_sum", res_sum, 0);
`endif
    rst_n = 1'b1; b_rst_n = 1'b1;

    // Table-driven basic sweep
    start = 1'b1; x_in = 3'd5; y_in = 3'd3;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      res_ready = vec[i].rdy;
      @(negedge clk);
      check("tb_busy", busy, vec[i].busy);
      check("tb_valid", res_valid, vec[i].valid);
      check("tb_done", done, vec[i].done);
      check("tb_alu_sel", alu_sel, vec[i].asel);
      if (vec[i].valid) begin
        check("tb_data", res_data, vec[i].data);
        check("tb_rsel", res_sel, vec[i].rsel);
      end
`ifdef LAB1_SEQ_CHECKSUM_EN
      if (i == 8) check("tb_sum", res_sum, 556);
`endif
    end

    // Backpressure on the sel=1 result
    res_ready = 1'b1; start = 1'b1; x_in = 3'd6; y_in = 3'd7;
    @(posedge clk); #1;
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (res_valid && res_sel == 2'd1) found = 1;
    end
    check("bp_wait", found, 1);
    res_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("bp_hold_valid", res_valid, 1);
      check("bp_hold_data", res_data, 8'h77);
      check("bp_hold_sel", res_sel, 1);
    end
    res_ready = 1'b1;
    @(negedge clk);
    check("bp_after_hs", res_valid, 0);
    @(negedge clk);
    check("bp_next_valid", res_valid, 1);
    check("bp_next_data", res_data, 8'hB7);
    check("bp_next_sel", res_sel, 2);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (done) found = 1;
    end
    check("bp_done", found, 1);

    // Start ignored mid-sweep; start in the done cycle begins the next sweep
    run_sweep(3'd1, 3'd2, 1'b0, 1'b1);
    run_sweep(3'd4, 3'd4, 1'b0, 1'b0);

    // Reset while a result is pending
    res_ready = 1'b0; start = 1'b1; x_in = 3'd3; y_in = 3'd5;
    @(posedge clk); #1;
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (res_valid) found = 1;
    end
    check("rs_wait_valid", found, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; res_ready = 1'b1;
    @(negedge clk);
    check("rs_busy", busy, 0);
    check("rs_valid", res_valid, 0);
    check("rs_done", done, 0);
    check("rs_alu", {alu_x, alu_y, alu_sel}, 0);
    check("rs_res", {res_sel, res_data}, 0);
`ifdef LAB1_SEQ_CHECKSUM_EN
    check("rs_sum", res_sum, 0);
`endif
    found = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) found = 1;
    end
    check("rs_quiet", found, 0);
    run_sweep(3'd3, 3'd5, 1'b0, 1'b0);

    // Randomized sweeps with random backpressure
    for (int n = 0; n < 25; n++) begin
      run_sweep(3'($urandom), 3'($urandom), 1'b1, ($urandom_range(0, 1) == 1));
    end
    @(negedge clk);
    check("final_done_low", done, 0);

    // SETTLE_CYCLES=3, LAST_SEL=2 instance, X=7, Y=2
    b_start = 1'b1; b_x = 3'd7; b_y = 3'd2; b_ready = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    for (int n = 0; n <= 13; n++) begin
      int  per;
      bit  ev;
      per = S2 + 1;
      @(negedge clk);
      ev = (n % per == S2) && (n < (L2 + 1) * per);
      check("p2_valid", b_valid, ev);
      if (ev) check("p2_data", b_data, (n / per) * 64 + 7 * 8 + 2);
      check("p2_done", b_done, n == (L2 + 1) * per);
      check("p2_busy", b_busy, n < (L2 + 1) * per);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
